hazard_stall_unit: RTL and testbench

Stall and flush controller for the 5-stage MIPS pipeline. Forwarding resolves data hazards by bypassing values. This block covers the cases bypassing cannot resolve:
- load-use dependencies;
- branches resolved in ID that need results not yet available;
- taken-branch squash of the IF/ID instruction;
- whole-pipeline freeze while data memory is busy.

It sits beside the ID stage. It drives the PC, IF/ID and ID/EX write/bubble controls, and keeps saturating stall/flush statistics.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_stall_unit.sv | 117 +++++++++++
 tb/tb_hazard_stall_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and stall-length constants for the pipeline hazard stall unit.
`default_nettype none

package hazard_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] STALL_LOAD_USE    = 2'd1;
  localparam logic [1:0] STALL_BR_ALU      = 2'd1;
  localparam logic [1:0] STALL_BR_LOAD_EX  = 2'd2;
  localparam logic [1:0] STALL_BR_LOAD_MEM = 2'd1;

  localparam logic [7:0] NOP_CTRL = 8'h00;

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // A zero destination never matches; Rt is compared only when the ID instruction reads it.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch stall, taken-branch flush and memory-busy freeze control.
`default_nettype none

module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_usesRt,
  input  logic             ID_isBranch,
  input  logic             branch_taken,
  input  logic             ID_Ex_MemRead,
  input  logic             ID_Ex_RegWrite,
  input  logic [4:0]       ID_Ex_WriteReg,
  input  logic             Ex_Mem_MemRead,
  input  logic [4:0]       Ex_Mem_WriteReg,
  input  logic             Mem_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_Ex_write,
  output logic             ID_Ex_bubble,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_t     r_state;
  logic [1:0] r_remaining;

  logic       w_match_ex;
  logic       w_match_mem;
  logic [1:0] w_need;
  logic       w_stall;

  assign w_match_ex  = reg_match(ID_Ex_WriteReg, IF_ID_Rs, IF_ID_Rt, ID_usesRt);
  assign w_match_mem = reg_match(Ex_Mem_WriteReg, IF_ID_Rs, IF_ID_Rt, ID_usesRt);

  always_comb begin
    w_need = 2'd0;
    if (ID_Ex_MemRead && w_match_ex && !ID_isBranch)
      w_need = max2(w_need, STALL_LOAD_USE);
    if (ID_isBranch && ID_Ex_RegWrite && !ID_Ex_MemRead && w_match_ex)
      w_need = max2(w_need, STALL_BR_ALU);
    if (ID_isBranch && ID_Ex_MemRead && w_match_ex)
      w_need = max2(w_need, STALL_BR_LOAD_EX);
    if (ID_isBranch && Ex_Mem_MemRead && w_match_mem)
      w_need = max2(w_need, STALL_BR_LOAD_MEM);
  end

  // Hazard inputs are only looked at in RUN; a pending STALL stalls unconditionally.
  assign w_stall = (r_state == STALL) || (w_need != 2'd0);

  always_comb begin
    PC_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_Ex_write  = 1'b0;
    ID_Ex_bubble = 1'b1;
    IF_ID_flush  = 1'b0;
    if (!reset) begin
      if (Mem_busy) begin
        ID_Ex_bubble = 1'b0;
      end else begin
        PC_write     = !w_stall;
        IF_ID_write  = !w_stall;
        ID_Ex_write  = 1'b1;
        ID_Ex_bubble = w_stall;
        IF_ID_flush  = ID_isBranch && branch_taken && !w_stall;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_remaining <= 2'd0;
    end else if (!Mem_busy) begin
      case (r_state)
        RUN: begin
          if (w_need == 2'd2) begin
            r_state     <= STALL;
            r_remaining <= w_need - 2'd1;
          end
        end
        STALL: begin
          r_remaining <= (r_remaining != 2'd0) ? r_remaining - 2'd1 : 2'd0;
          if (r_remaining <= 2'd1)
            r_state <= RUN;
        end
        default: begin
          r_state     <= RUN;
          r_remaining <= 2'd0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!PC_write),
    .value (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (IF_ID_flush),
    .value (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed-vector checks of stall, flush, freeze, reset and saturation behaviour.
`default_nettype none

module tb_hazard_stall_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       IF_ID_Rs, IF_ID_Rt, ID_Ex_WriteReg, Ex_Mem_WriteReg;
  logic             ID_usesRt, ID_isBranch, branch_taken;
  logic             ID_Ex_MemRead, ID_Ex_RegWrite, Ex_Mem_MemRead, Mem_busy;
  logic             PC_write, IF_ID_write, ID_Ex_write, ID_Ex_bubble, IF_ID_flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_Rs        (IF_ID_Rs),
    .IF_ID_Rt        (IF_ID_Rt),
    .ID_usesRt       (ID_usesRt),
    .ID_isBranch     (ID_isBranch),
    .branch_taken    (branch_taken),
    .ID_Ex_MemRead   (ID_Ex_MemRead),
    .ID_Ex_RegWrite  (ID_Ex_RegWrite),
    .ID_Ex_WriteReg  (ID_Ex_WriteReg),
    .Ex_Mem_MemRead  (Ex_Mem_MemRead),
    .Ex_Mem_WriteReg (Ex_Mem_WriteReg),
    .Mem_busy        (Mem_busy),
    .PC_write        (PC_write),
    .IF_ID_write     (IF_ID_write),
    .ID_Ex_write     (ID_Ex_write),
    .ID_Ex_bubble    (ID_Ex_bubble),
    .IF_ID_flush     (IF_ID_flush),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control vector order: PC_write, IF_ID_write, ID_Ex_write, ID_Ex_bubble, IF_ID_flush.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, PC_write, IF_ID_write, ID_Ex_write, ID_Ex_bubble, IF_ID_flush}, {27'd0, exp});
  endtask

  task automatic idle();
    IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_usesRt = 1'b0;
    ID_isBranch = 1'b0; branch_taken = 1'b0;
    ID_Ex_MemRead = 1'b0; ID_Ex_RegWrite = 1'b0; ID_Ex_WriteReg = 5'd0;
    Ex_Mem_MemRead = 1'b0; Ex_Mem_WriteReg = 5'd0; Mem_busy = 1'b0;
  endtask

  // Inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next(); reset = 1'b1; idle();
    next(); reset = 1'b0;
  endtask

  task automatic branch_on_load_ex();
    idle();
    ID_isBranch = 1'b1; branch_taken = 1'b1;
    IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd9; ID_usesRt = 1'b1;
    ID_Ex_MemRead = 1'b1; ID_Ex_RegWrite = 1'b1; ID_Ex_WriteReg = 5'd9;
  endtask

  task automatic branch_no_hazard();
    idle();
    ID_isBranch = 1'b1; branch_taken = 1'b1;
    IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd9; ID_usesRt = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check_ctl("reset_ctl", 5'b00010);
    check("reset_stall_cnt", {28'd0, stall_cycles}, 32'd0);
    check("reset_flush_cnt", {28'd0, flush_count}, 32'd0);
    next(); reset = 1'b0;
    #1 check_ctl("idle_run", 5'b11100);

    // Load-use on Rs
    next(); ID_Ex_MemRead = 1'b1; ID_Ex_RegWrite = 1'b1; ID_Ex_WriteReg = 5'd8; IF_ID_Rs = 5'd8;
    #1 check_ctl("load_use_stall", 5'b00110);
    next(); idle();
    #1 check_ctl("load_use_clear", 5'b11100);
    check("load_use_cnt", {28'd0, stall_cycles}, 32'd1);

    // Rt match ignored when Rt is not a source
    next(); ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd7; IF_ID_Rt = 5'd7; ID_usesRt = 1'b0;
    #1 check_ctl("rt_unused_no_stall", 5'b11100);
    next(); ID_usesRt = 1'b1;
    #1 check_ctl("rt_used_stall", 5'b00110);
    next(); idle();
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd0;
    #1 check_ctl("load_dst0_no_stall", 5'b11100);

    // Branch on load: 2 stall cycles then flush
    do_reset();
    branch_on_load_ex();
    #1 check_ctl("brload_c1", 5'b00110);
    next(); branch_no_hazard(); Ex_Mem_MemRead = 1'b1; Ex_Mem_WriteReg = 5'd9;
    #1 check_ctl("brload_c2", 5'b00110);
    next(); branch_no_hazard();
    #1 check_ctl("brload_resolve_flush", 5'b11101);
    next(); idle();
    #1 check_ctl("brload_after", 5'b11100);
    check("brload_stall_cnt", {28'd0, stall_cycles}, 32'd2);
    check("brload_flush_cnt", {28'd0, flush_count}, 32'd1);

    // Branch on ALU result, then $0 destination
    do_reset();
    ID_isBranch = 1'b1; IF_ID_Rs = 5'd10; ID_Ex_RegWrite = 1'b1; ID_Ex_WriteReg = 5'd10;
    #1 check_ctl("bralu_stall", 5'b00110);
    next(); idle(); ID_isBranch = 1'b1; IF_ID_Rs = 5'd10;
    #1 check_ctl("bralu_resolve_nt", 5'b11100);
    next(); idle(); ID_isBranch = 1'b1; branch_taken = 1'b1; ID_Ex_RegWrite = 1'b1;
    #1 check_ctl("br_dst0_flush", 5'b11101);
    check("bralu_stall_cnt", {28'd0, stall_cycles}, 32'd1);

    // Freeze in RUN overrides a load-use hazard
    next(); idle(); ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd8; IF_ID_Rs = 5'd8; Mem_busy = 1'b1;
    #1 check_ctl("freeze_run", 5'b00000);

    // Freeze 3 cycles inside a 2-cycle branch stall
    do_reset();
    branch_on_load_ex();
    #1 check_ctl("frz_c1", 5'b00110);
    for (int i = 0; i < 3; i++) begin
      next(); branch_no_hazard(); Mem_busy = 1'b1;
      #1 check_ctl($sformatf("frz_busy%0d", i), 5'b00000);
    end
    next(); branch_no_hazard();
    #1 check_ctl("frz_stall_held", 5'b00110);
    next(); branch_no_hazard();
    #1 check_ctl("frz_resolve_flush", 5'b11101);
    next(); idle();
    #1 check("frz_stall_cnt", {28'd0, stall_cycles}, 32'd5);
    check("frz_flush_cnt", {28'd0, flush_count}, 32'd1);

    // Reset in the middle of STALL
    do_reset();
    branch_on_load_ex();
    next(); idle(); reset = 1'b1;
    #1 check_ctl("rst_mid_ctl", 5'b00010);
    check("rst_mid_cnt", {28'd0, stall_cycles}, 32'd0);
    next(); reset = 1'b0;
    #1 check_ctl("rst_mid_run", 5'b11100);
    check("rst_mid_cnt_after", {28'd0, stall_cycles}, 32'd0);

    // Saturation of both counters
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle(); ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd8; IF_ID_Rs = 5'd8;
      next();
    end
    idle();
    #1 check("sat_stall", {28'd0, stall_cycles}, 32'd15);
    for (int i = 0; i < 18; i++) begin
      branch_no_hazard();
      next();
    end
    idle();
    #1 check("sat_flush", {28'd0, flush_count}, 32'd15);
    check("sat_stall_hold", {28'd0, stall_cycles}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
